instr_mem_pipelined: RTL and testbench

INSTR_MEM_PIPELINED -- requirements
Module: instr_mem_pipelined

---
 rtl/instr_mem_pipelined_pkg.sv | 13 +
 rtl/instr_mem_pipelined_array.sv | 30 +++
 rtl/instr_mem_pipelined.sv | 122 ++++++++++++
 tb/tb_instr_mem_pipelined.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pipelined_pkg.sv
// Shared constants and FSM state type for the pipelined instruction memory.
package instr_mem_pipelined_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef logic [0:0] state_t;
  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/instr_mem_pipelined_array.sv
// Word storage: one write port and one registered read port (read-before-write).
module instr_mem_array #(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;

  // Read only on demand so a held response keeps its word even if it is later overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_pipelined.sv
// Instruction fetch memory: NOP fill after reset, then latency-1 fetches with
// alignment/range fault reporting and a program-load write port.
module instr_mem_pipelined
  import instr_mem_pipelined_pkg::*;
#(
  parameter  int          ADDR_W   = 64,
  parameter  int          DEPTH    = 256,
  parameter  logic [31:0] NOP_WORD = NOP_WORD_DEFAULT,
  localparam int          IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [31:0]       ld_data,
  output logic              init_done
);

  localparam logic [ADDR_W:0] RANGE_LIMIT = (ADDR_W+1)'(DEPTH) << 2;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_fault_q, rsp_fault_d;
  logic             data_ok_q, data_ok_d;

  logic             running;
  logic             accept;
  logic             fault_mis;
  logic             fault_rng;
  logic [IDX_W-1:0] rd_idx;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  assign running   = (state_q == ST_RUN);
  assign req_ready = running && !flush && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rd_idx    = req_addr[IDX_W+1:2];
  assign fault_mis = (req_addr[1:0] != 2'b00);
  assign fault_rng = ({1'b0, req_addr} >= RANGE_LIMIT);

  always_comb begin
    state_d     = state_q;
    fill_idx_d  = fill_idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    data_ok_d   = data_ok_q;

    if (state_q == ST_INIT) begin
      fill_idx_d = fill_idx_q + 1'b1;
      if (fill_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end

    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (accept) begin
      rsp_fault_d[FAULT_MISALIGN] = fault_mis;
      rsp_fault_d[FAULT_RANGE]    = fault_rng;
      data_ok_d                   = !fault_mis && !fault_rng;
    end
  end

  // The fill owns the write port until RUN; loads are ignored before then.
  always_comb begin
    mem_we    = running ? ld_en   : 1'b1;
    mem_waddr = running ? ld_addr : fill_idx_q;
    mem_wdata = running ? ld_data : NOP_WORD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      fill_idx_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 2'b00;
      data_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_idx_q  <= fill_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      data_ok_q   <= data_ok_d;
    end
  end

  instr_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_en   (accept),
    .rd_addr (rd_idx),
    .rd_data (mem_rdata)
  );

  // Faulted or reset responses present the NOP word instead of the array output.
  assign rsp_data  = data_ok_q ? mem_rdata : NOP_WORD;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign init_done = running;

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Scoreboard bench for instr_mem_pipelined: a driver predicts responses from a
// word-array model, a negedge monitor pops and compares what the DUT presents.
module tb_instr_mem_pipelined;

  localparam int          ADDR_W = 64;
  localparam int          DEPTH  = 256;
  localparam int          IDX_W  = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_fault;
  logic              flush = 1'b0;
  logic              ld_en = 1'b0;
  logic [IDX_W-1:0]  ld_addr = '0;
  logic [31:0]       ld_data = '0;
  logic              init_done;

  always #5 clk = ~clk;

  instr_mem_pipelined #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_done (init_done)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  bit          model_busy = 1'b0;
  bit          model_run  = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: byte address -> word, faults from plain arithmetic on the address.
  function automatic exp_t predict(input logic [63:0] a);
    exp_t e;
    bit   mis;
    bit   rng;
    int   idx;
    mis     = (a % 64'd4) != 0;
    rng     = a >= 64'(DEPTH * 4);
    idx     = int'((a / 64'd4) % 64'(DEPTH));
    e.addr  = a;
    e.fault = {rng, mis};
    e.data  = (mis || rng) ? NOP : model_mem[idx];
    return e;
  endfunction

  function automatic logic [63:0] rand_addr();
    int sel;
    sel = int'($urandom % 8);
    if (sel < 5)       return 64'({$urandom % DEPTH, 2'b00});
    else if (sel == 5) return 64'($urandom % (DEPTH * 4));
    else if (sel == 6) return 64'(DEPTH * 4 + $urandom % (DEPTH * 4));
    else               return {$urandom, $urandom};
  endfunction

  // One clock of stimulus; prediction happens before the same-cycle load is applied.
  task automatic cycle(input bit v, input logic [63:0] a, input bit rr, input bit fl,
                       input bit le, input int la, input logic [31:0] ld, output bit acc);
    exp_t e;
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    ld_en     = le;
    ld_addr   = IDX_W'(la);
    ld_data   = ld;
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(model_busy));
    check("req_ready", 64'(req_ready), 64'(model_run && !fl && (!model_busy || rr)));
    acc = v && req_ready;
    if (acc) e = predict(a);
    @(posedge clk);
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(e);
    if (le && model_run) model_mem[la] = ld;
    model_busy = fl ? 1'b0 : (acc ? 1'b1 : (rr ? 1'b0 : model_busy));
    #1;
  endtask

  task automatic fetch(input logic [63:0] a, input bit rr);
    bit acc;
    cycle(1'b1, a, rr, 1'b0, 1'b0, 0, 32'h0, acc);
  endtask

  task automatic idle(input bit rr);
    bit acc;
    cycle(1'b0, 64'h0, rr, 1'b0, 1'b0, 0, 32'h0, acc);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'(NOP));
    check("reset_rsp_fault", 64'(rsp_fault), 64'd0);
    check("reset_init_done", 64'(init_done), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    model_busy = 1'b0;
    model_run  = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    reset = 1'b0;
  endtask

  // Counts rising edges until init_done; optional junk loads must be ignored.
  task automatic wait_init(input bit junk_ld);
    int cnt;
    cnt     = 0;
    ld_en   = junk_ld;
    ld_addr = '0;
    ld_data = 32'hDEAD_BEEF;
    while (!init_done && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    ld_en = 1'b0;
    check("init_cycles", 64'(cnt), 64'd256);
    model_run = 1'b1;
    $display("init_done after %0d cycles", cnt);
  endtask

  // Monitor: pops on every transfer and checks held responses stay stable.
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_fault;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_hold && rsp_valid) begin
        check("hold_data", 64'(rsp_data), 64'(prev_data));
        check("hold_fault", 64'(rsp_fault), 64'(prev_fault));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %0h, expected no response", rsp_data);
        end else begin
          e = exp_q.pop_front();
          $display("rsp addr=%0h data=%08h fault=%02b (exp %08h %02b)",
                   e.addr, rsp_data, rsp_fault, e.data, e.fault);
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
        end
      end
      prev_hold  = rsp_valid && !rsp_ready && !reset;
      prev_data  = rsp_data;
      prev_fault = rsp_fault;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    do_reset();
    wait_init(1'b1);

    fetch(64'h0, 1'b1);
    for (int i = 0; i < 10; i++) fetch(64'({$urandom % DEPTH, 2'b00}), 1'b1);
    idle(1'b1);

    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 0, 32'h3c01_1001, acc);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 3, 32'h342d_0030, acc);
    fetch(64'h0, 1'b1);
    fetch(64'hC, 1'b1);
    idle(1'b1);

    fetch(64'h2, 1'b1);
    fetch(64'h400, 1'b1);
    fetch(64'h402, 1'b1);
    fetch(64'h1_0000_0000, 1'b1);
    idle(1'b1);

    fetch(64'h0, 1'b0);
    repeat (3) fetch(64'hC, 1'b0);
    cycle(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 0, 32'h0, acc);
    check("same_cycle_accept", 64'(acc), 64'd1);
    idle(1'b1);

    cycle(1'b1, 64'h14, 1'b1, 1'b0, 1'b1, 5, 32'hAAAA_0000, acc);
    fetch(64'h14, 1'b1);
    idle(1'b1);

    fetch(64'h4, 1'b0);
    cycle(1'b1, 64'h8, 1'b0, 1'b1, 1'b0, 0, 32'h0, acc);
    idle(1'b1);

    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom % 2), rand_addr(), ($urandom % 4) != 0, ($urandom % 16) == 0,
            ($urandom % 4) == 0, int'($urandom % DEPTH), $urandom, acc);
    end
    repeat (3) idle(1'b1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    fetch(64'h4, 1'b0);
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    do_reset();
    wait_init(1'b0);
    fetch(64'h14, 1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
